lcd1602_bus_ctrl: RTL and testbench

Timing-correct bus controller for an HD44780-compatible 1602 character LCD on an 8-bit parallel bus, write-only.
- After reset it runs the power-up wait and a fixed init command sequence.
- It then accepts single-byte command/data writes from a client over a valid/ready handshake.
- For each write it generates E setup, pulse and hold timing, followed by the controller execution wait.
- It sits between text/command sequencers and the LCD pins; clients never drive E directly.

---
 rtl/lcd1602_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_lcd1602_bus_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_bus_ctrl.sv
// Write-only HD44780 (1602) 8-bit bus controller: power-up wait, fixed init
// sequence, then single-byte client writes with E setup/pulse/hold and execution wait.
module lcd1602_bus_ctrl #(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 3,
    parameter int T_PW      = 12,
    parameter int T_HOLD    = 3,
    parameter int T_EXEC    = 2000,
    parameter int T_LONG    = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat
);

    localparam int T_MAX_A = (T_POWERUP > T_LONG) ? T_POWERUP : T_LONG;
    localparam int T_MAX_B = (T_EXEC > T_PW) ? T_EXEC : T_PW;
    localparam int T_MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
    localparam int CW      = $clog2(T_MAX + 1);

    // Terminal counter value for a state lasting n cycles (never shorter than one).
    function automatic logic [CW-1:0] last_cnt(input int n);
        return (n > 1) ? CW'(n - 1) : '0;
    endfunction

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    typedef enum logic [2:0] {PWR_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

    // INIT_LOAD takes one cycle of the preceding wait, so load-to-load spacing stays exact.
    localparam logic [CW-1:0] PWR_LAST   = last_cnt(T_POWERUP - 1);
    localparam logic [CW-1:0] SETUP_LAST = last_cnt(T_SETUP);
    localparam logic [CW-1:0] PW_LAST    = last_cnt(T_PW);
    localparam logic [CW-1:0] HOLD_LAST  = last_cnt(T_HOLD);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    init_idx;
    logic          long_wait;
    logic          to_init;
    int            wait_n;
    logic [CW-1:0] wait_last;

    assign lcd_rw    = 1'b0;
    assign long_wait = !lcd_rs && (lcd_dat == 8'h01 || lcd_dat == 8'h02 || lcd_dat == 8'h03);
    assign to_init   = !init_done && (init_idx != 2'd3);

    always_comb begin
        wait_n = long_wait ? T_LONG : T_EXEC;
        if (to_init)
            wait_n = wait_n - 1;
        wait_last = last_cnt(wait_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_WAIT;
            cnt       <= '0;
            init_idx  <= 2'd0;
            init_done <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_dat   <= 8'h00;
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (cnt == PWR_LAST) begin
                        cnt   <= '0;
                        state <= INIT_LOAD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                INIT_LOAD: begin
                    lcd_rs  <= 1'b0;
                    lcd_dat <= init_rom(init_idx);
                    cnt     <= '0;
                    state   <= SETUP;
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt    <= '0;
                        lcd_en <= 1'b1;
                        state  <= PULSE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt == PW_LAST) begin
                        cnt    <= '0;
                        lcd_en <= 1'b0;
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (cnt == wait_last) begin
                        cnt <= '0;
                        if (to_init) begin
                            init_idx <= init_idx + 2'd1;
                            state    <= INIT_LOAD;
                        end else begin
                            init_done <= 1'b1;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lcd_rs    <= req_rs;
                        lcd_dat   <= req_data;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= SETUP;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd1602_bus_ctrl.sv
// Directed bench for lcd1602_bus_ctrl: init sequence, table of single writes,
// back-to-back writes, request during init and reset in the middle of an E pulse.
module tb_lcd1602_bus_ctrl;

    localparam int T_POWERUP = 20;
    localparam int T_SETUP   = 2;
    localparam int T_PW      = 4;
    localparam int T_HOLD    = 2;
    localparam int T_EXEC    = 10;
    localparam int T_LONG    = 40;
    localparam int XFER      = T_SETUP + T_PW + T_HOLD;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       init_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_dat;

    lcd1602_bus_ctrl #(
        .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_PW(T_PW),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_LONG(T_LONG)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
        .req_ready(req_ready), .init_done(init_done), .busy(busy), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         low;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] init_exp [4];
    int         n_vec;
    int         n_bad;

    int         pk [$];
    logic [7:0] pd [$];
    logic       pr [$];
    int         pw [$];
    int         done_k;
    int         rdy_k;
    int         acc_k;
    int         unstable;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Observes n cycles (first sample after the first edge) and records every E pulse.
    task automatic watch(input int n);
        logic       pe;
        logic [7:0] hd;
        logic       hr;
        pk.delete(); pd.delete(); pr.delete(); pw.delete();
        done_k = -1; rdy_k = -1; acc_k = -1; unstable = 0;
        pe = lcd_en; hd = lcd_dat; hr = lcd_rs;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (lcd_en && !pe) begin
                pk.push_back(k); pd.push_back(lcd_dat); pr.push_back(lcd_rs); pw.push_back(1);
                hd = lcd_dat; hr = lcd_rs;
            end else if (lcd_en && pe) begin
                pw[pw.size()-1] = pw[pw.size()-1] + 1;
                if (lcd_dat !== hd || lcd_rs !== hr) unstable++;
            end
            pe = lcd_en;
            if (init_done && done_k < 0) done_k = k;
            if (req_ready && rdy_k < 0) rdy_k = k;
            if (req_ready && req_valid && acc_k < 0) acc_k = k;
        end
    endtask

    task automatic check_init_seq(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_e%0d_at", tag, i), (i < pk.size()) ? pk[i] : -1,
                T_POWERUP + T_SETUP + i * (XFER + T_EXEC));
            chk($sformatf("%s_e%0d_dat", tag, i), (i < pd.size()) ? int'(pd[i]) : -1, int'(init_exp[i]));
            chk($sformatf("%s_e%0d_rs", tag, i), (i < pr.size()) ? int'(pr[i]) : -1, 0);
            chk($sformatf("%s_e%0d_w", tag, i), (i < pw.size()) ? pw[i] : -1, T_PW);
        end
        chk({tag, "_done_at"}, done_k, 122);
        chk({tag, "_ready_at"}, rdy_k, 122);
        chk({tag, "_e_stable"}, unstable, 0);
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 300 && !req_ready; k++) @(negedge clk);
        chk({tag, "_ready"}, int'(req_ready), 1);
    endtask

    task automatic do_write(input int idx, input logic rs, input logic [7:0] d, input int exp_low);
        int low, e_first, e_last, e_cnt, bad_hold, bad_busy;
        wait_ready($sformatf("wr%0d", idx));
        req_valid = 1'b1; req_rs = rs; req_data = d;
        @(negedge clk);
        req_valid = 1'b0;
        low = 0; e_first = -1; e_last = -1; e_cnt = 0; bad_hold = 0; bad_busy = 0;
        for (int k = 1; k <= 300; k++) begin
            if (req_ready) break;
            low++;
            if (lcd_en) begin
                if (e_first < 0) e_first = k;
                e_last = k;
                e_cnt++;
            end
            if (lcd_rs !== rs || lcd_dat !== d) bad_hold++;
            if (busy !== 1'b1) bad_busy++;
            @(negedge clk);
        end
        chk($sformatf("wr%0d_ready_low", idx), low, exp_low);
        chk($sformatf("wr%0d_e_first", idx), e_first, T_SETUP + 1);
        chk($sformatf("wr%0d_e_last", idx), e_last, T_SETUP + T_PW);
        chk($sformatf("wr%0d_e_cycles", idx), e_cnt, T_PW);
        chk($sformatf("wr%0d_rs_dat_held", idx), bad_hold, 0);
        chk($sformatf("wr%0d_busy_high", idx), bad_busy, 0);
        chk($sformatf("wr%0d_busy_idle", idx), int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         e_first2, e_first1, acc2;
        logic       pe, drop;
        logic [7:0] d1, d2;
        int         unst;

        n_vec = 0; n_bad = 0;
        tbl[0] = '{rs: 1'b1, data: 8'h48, low: XFER + T_EXEC};
        tbl[1] = '{rs: 1'b0, data: 8'h01, low: XFER + T_LONG};
        tbl[2] = '{rs: 1'b1, data: 8'h01, low: XFER + T_EXEC};
        tbl[3] = '{rs: 1'b0, data: 8'h02, low: XFER + T_LONG};
        tbl[4] = '{rs: 1'b0, data: 8'h03, low: XFER + T_LONG};
        tbl[5] = '{rs: 1'b0, data: 8'h04, low: XFER + T_EXEC};
        tbl[6] = '{rs: 1'b1, data: 8'h02, low: XFER + T_EXEC};
        init_exp[0] = 8'h38; init_exp[1] = 8'h0C; init_exp[2] = 8'h06; init_exp[3] = 8'h01;

        rst = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_lcd_en", int'(lcd_en), 0);
        chk("rst_lcd_rs", int'(lcd_rs), 0);
        chk("rst_lcd_dat", int'(lcd_dat), 0);
        chk("rst_lcd_rw", int'(lcd_rw), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_busy", int'(busy), 1);

        // Power-up and init with no client traffic
        rst = 1'b0;
        watch(130);
        check_init_seq("init");
        chk("init_npulse", pk.size(), 4);
        chk("init_busy_idle", int'(busy), 0);

        for (int i = 0; i < 7; i++)
            do_write(i, tbl[i].rs, tbl[i].data, tbl[i].low);

        // Back-to-back: valid stays high, second byte presented right after the first accept
        wait_ready("b2b");
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h48;
        @(negedge clk);
        req_data = 8'h69;
        e_first1 = -1; e_first2 = -1; acc2 = -1; drop = 1'b0; unst = 0;
        d1 = 8'h00; d2 = 8'h00; pe = lcd_en;
        for (int k = 1; k <= 45; k++) begin
            if (drop) req_valid = 1'b0;
            if (lcd_en && !pe) begin
                if (e_first1 < 0) begin e_first1 = k; d1 = lcd_dat; end
                else if (e_first2 < 0) begin e_first2 = k; d2 = lcd_dat; end
            end
            if (lcd_en && pe && lcd_dat !== ((e_first2 < 0) ? d1 : d2)) unst++;
            pe = lcd_en;
            if (req_ready && req_valid && acc2 < 0) begin acc2 = k; drop = 1'b1; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_accept2_at", acc2, XFER + T_EXEC + 1);
        chk("b2b_e1_at", e_first1, T_SETUP + 1);
        // One ready-high cycle separates the two transactions
        chk("b2b_e_spacing", e_first2 - e_first1, XFER + T_EXEC + 1);
        chk("b2b_e1_dat", int'(d1), 8'h48);
        chk("b2b_e2_dat", int'(d2), 8'h69);
        chk("b2b_dat_stable", unst, 0);

        // Request held from reset release onward
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
        watch(140);
        req_valid = 1'b0;
        check_init_seq("initreq");
        chk("initreq_accept_at", acc_k, 122);
        chk("initreq_npulse", pk.size(), 5);
        chk("initreq_e4_at", (pk.size() > 4) ? pk[4] : -1, 122 + 1 + T_SETUP);
        chk("initreq_e4_dat", (pd.size() > 4) ? int'(pd[4]) : -1, 8'h41);
        chk("initreq_e4_rs", (pr.size() > 4) ? int'(pr[4]) : -1, 1);

        // Reset while E is high during a client write
        wait_ready("midrst");
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 20 && !lcd_en; k++) @(negedge clk);
        chk("midrst_en_seen", int'(lcd_en), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_lcd_en", int'(lcd_en), 0);
        chk("midrst_init_done", int'(init_done), 0);
        chk("midrst_req_ready", int'(req_ready), 0);
        chk("midrst_busy", int'(busy), 1);
        rst = 1'b0;
        watch(130);
        check_init_seq("reinit");
        chk("reinit_npulse", pk.size(), 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
